// File: rtl/fifo_pkg.sv
// Shared types and constants for the block-RAM synchronous FIFO and its RAM core.
package fifo_pkg;

    localparam int DEF_DATA_WIDTH    = 36;
    localparam int DEF_ADDR_WIDTH    = 8;
    localparam int DEF_AFULL_MARGIN  = 4;
    localparam int DEF_AEMPTY_THRESH = 4;

    // Occupancy needs one extra bit so that a completely full FIFO (DEPTH) is representable.
    function automatic int cnt_w(input int addr_width);
        return addr_width + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } err_flags_t;

endpackage

// File: rtl/sdpram_core.sv
// Simple dual-port RAM: one write port and one registered read port with read enable.
module sdpram_core #(
    parameter int DATA_WIDTH = 36,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Only the output register is reset; it holds its value when no read is enabled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_data <= '0;
        end else if (rd_en_i) begin
            r_rd_data <= r_mem[rd_addr_i];
        end
    end

    assign rd_data_o = r_rd_data;

endmodule

// File: rtl/sync_fifo_bram.sv
// Single-clock FIFO around sdpram_core: pointers, occupancy, registered flags,
// read-valid pulse and sticky overflow/underflow error flags.
module sync_fifo_bram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - DEF_AFULL_MARGIN,
    parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             wr_en_i,
    input  logic [DATA_WIDTH-1:0]            wr_data_i,
    output logic                             full_o,
    output logic                             almost_full_o,
    input  logic                             rd_en_i,
    output logic [DATA_WIDTH-1:0]            rd_data_o,
    output logic                             rd_valid_o,
    output logic                             empty_o,
    output logic                             almost_empty_o,
    output logic [cnt_w(ADDR_WIDTH)-1:0]     count_o,
    output logic                             overflow_o,
    output logic                             underflow_o
);

    localparam int CW    = cnt_w(ADDR_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AEMPTY_THRESH);

    logic [CW-1:0] r_wptr;
    logic [CW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_full;
    logic          r_empty;
    logic          r_afull;
    logic          r_aempty;
    logic          r_rd_valid;
    err_flags_t    r_err;

    logic          w_wr_acc;
    logic          w_rd_acc;
    logic          w_wr_rej;
    logic          w_rd_rej;
    logic [CW-1:0] w_count_nxt;

    // Handshake: a request is taken when its enable is high and the registered
    // full/empty flag allows it; an accepted read returns data with rd_valid_o
    // exactly one cycle later. Reset overrides every request in its cycle.
    assign w_wr_acc = wr_en_i & ~r_full  & ~rst_i;
    assign w_rd_acc = rd_en_i & ~r_empty & ~rst_i;
    assign w_wr_rej = wr_en_i &  r_full  & ~rst_i;
    assign w_rd_rej = rd_en_i &  r_empty & ~rst_i;

    assign w_count_nxt = r_count + {{(CW-1){1'b0}}, w_wr_acc} - {{(CW-1){1'b0}}, w_rd_acc};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_afull    <= 1'b0;
            r_aempty   <= 1'b1;
            r_rd_valid <= 1'b0;
            r_err      <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_acc) begin
                r_rptr <= r_rptr + 1'b1;
            end
            // Flags come from the next count so they line up with count_o.
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == DEPTH_C);
            r_empty    <= (w_count_nxt == '0);
            r_afull    <= (w_count_nxt >= AF_C);
            r_aempty   <= (w_count_nxt <= AE_C);
            r_rd_valid <= w_rd_acc;
            r_err.overflow  <= r_err.overflow  | w_wr_rej;
            r_err.underflow <= r_err.underflow | w_rd_rej;
        end
    end

    sdpram_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (w_wr_acc),
        .wr_addr_i (r_wptr[ADDR_WIDTH-1:0]),
        .wr_data_i (wr_data_i),
        .rd_en_i   (w_rd_acc),
        .rd_addr_i (r_rptr[ADDR_WIDTH-1:0]),
        .rd_data_o (rd_data_o)
    );

    // A pulse still pending from a read just before reset is masked for the reset cycle.
    assign rd_valid_o     = r_rd_valid & ~rst_i;
    assign full_o         = r_full;
    assign empty_o        = r_empty;
    assign almost_full_o  = r_afull;
    assign almost_empty_o = r_aempty;
    assign count_o        = r_count;
    assign overflow_o     = r_err.overflow;
    assign underflow_o    = r_err.underflow;

endmodule
